// File: rtl/booth_div_pkg.sv
// Shared types and sizing helpers for the booth_div signed divider.
package booth_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic int div_latency(input int d_in);
    return 2 * d_in + 2;
  endfunction

  function automatic int div_cnt_w(input int d_in);
    return $clog2(2 * d_in);
  endfunction

endpackage

// File: rtl/booth_div_sign.sv
// Magnitude and sign-restore unit for booth_div: operand abs values, signed Q/R, overflow.
// With BOOTH_DIV_SAT_EN defined, an overflowing quotient saturates instead of wrapping.
module booth_div_sign
  import booth_div_pkg::*;
#(
  parameter int D_IN = 8
) (
  input  logic [2*D_IN-1:0] i_n,
  input  logic [D_IN-1:0]   i_d,
  input  logic [2*D_IN-1:0] i_q_mag,
  input  logic [D_IN-1:0]   i_r_mag,
  input  logic              i_q_neg,
  input  logic              i_r_neg,
  output logic [2*D_IN-1:0] o_n_mag,
  output logic [D_IN:0]     o_d_mag,
  output logic [D_IN-1:0]   o_q,
  output logic [D_IN-1:0]   o_r,
  output logic              o_ovf
);
  localparam int NW = 2 * D_IN;
  localparam logic [D_IN-1:0] Q_MAX = {1'b0, {(D_IN-1){1'b1}}};
  localparam logic [D_IN-1:0] Q_MIN = {1'b1, {(D_IN-1){1'b0}}};

  logic [D_IN:0]        w_d_ext;
  logic [NW:0]          w_q_ext;
  logic [NW:0]          w_q_s;
  logic [NW-D_IN+1:0]   w_q_hi;

  // |N| <= 2^(NW-1) always fits the unsigned NW-bit result, so the most negative N cannot wrap
  assign o_n_mag = i_n[NW-1] ? (~i_n + {{(NW-1){1'b0}}, 1'b1}) : i_n;
  assign w_d_ext = {i_d[D_IN-1], i_d};
  assign o_d_mag = i_d[D_IN-1] ? (~w_d_ext + {{D_IN{1'b0}}, 1'b1}) : w_d_ext;

  assign w_q_ext = {1'b0, i_q_mag};
  assign w_q_s   = i_q_neg ? (~w_q_ext + {{NW{1'b0}}, 1'b1}) : w_q_ext;
  assign w_q_hi  = w_q_s[NW:D_IN-1];
  assign o_ovf   = ~((&w_q_hi) | (~|w_q_hi));

`ifdef BOOTH_DIV_SAT_EN
  assign o_q = o_ovf ? (i_q_neg ? Q_MIN : Q_MAX) : w_q_s[D_IN-1:0];
`else
  assign o_q = w_q_s[D_IN-1:0];
`endif

  assign o_r = i_r_neg ? (~i_r_mag + {{(D_IN-1){1'b0}}, 1'b1}) : i_r_mag;

endmodule

// File: rtl/booth_div.sv
// booth_div: sequential signed restoring divider, 2*D_IN-bit dividend by D_IN-bit divisor.
// Optional macro BOOTH_DIV_SAT_EN (in booth_div_sign) saturates Q on overflow.
module booth_div
  import booth_div_pkg::*;
#(
  parameter int D_IN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [2*D_IN-1:0]   N,
  input  logic [D_IN-1:0]     D,
  output logic                busy,
  output logic                done,
  output logic [D_IN-1:0]     Q,
  output logic [D_IN-1:0]     R,
  output logic                ovf,
  output logic                div_zero
);
  localparam int NW = 2 * D_IN;
  localparam int CW = div_cnt_w(D_IN);
  localparam logic [D_IN-1:0] Q_MAX = {1'b0, {(D_IN-1){1'b1}}};
  localparam logic [D_IN-1:0] Q_MIN = {1'b1, {(D_IN-1){1'b0}}};

  state_e            r_state;
  state_e            w_next;
  logic              w_load;
  logic [CW-1:0]     r_cnt;
  logic [NW-1:0]     r_q;
  logic [D_IN:0]     r_rem;
  logic [D_IN:0]     r_d_mag;
  logic              r_q_neg;
  logic              r_n_neg;
  logic              r_dz;
  logic              r_busy;
  logic              r_done;
  logic [D_IN-1:0]   r_quo;
  logic [D_IN-1:0]   r_rmd;
  logic              r_ovf;
  logic              r_div_zero;
  logic [NW-1:0]     w_n_mag;
  logic [D_IN:0]     w_d_mag;
  logic [D_IN-1:0]   w_q;
  logic [D_IN-1:0]   w_r;
  logic              w_ovf;
  logic [D_IN+1:0]   w_shift;
  logic [D_IN+1:0]   w_trial;

  booth_div_sign #(.D_IN(D_IN)) u_sign (
    .i_n     (N),
    .i_d     (D),
    .i_q_mag (r_q),
    .i_r_mag (r_rem[D_IN-1:0]),
    .i_q_neg (r_q_neg),
    .i_r_neg (r_n_neg),
    .o_n_mag (w_n_mag),
    .o_d_mag (w_d_mag),
    .o_q     (w_q),
    .o_r     (w_r),
    .o_ovf   (w_ovf)
  );

  // one restoring step: shift in the next dividend bit, trial-subtract |D|
  assign w_shift = {r_rem, r_q[NW-1]};
  assign w_trial = w_shift - {1'b0, r_d_mag};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_load = 1'b0;
    case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_next = CALC;
          w_load = 1'b1;
        end else begin
          w_next = IDLE;
        end
      end
      CALC: begin
        if (r_cnt == {CW{1'b0}}) w_next = FIX;
        else                     w_next = CALC;
      end
      FIX:     w_next = DONE;
      default: w_next = IDLE;
    endcase
  end

  // done is registered off DONE so the pulse lands 2*D_IN+2 cycles after the accepting edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= {CW{1'b0}};
      r_q        <= {NW{1'b0}};
      r_rem      <= {(D_IN+1){1'b0}};
      r_d_mag    <= {(D_IN+1){1'b0}};
      r_q_neg    <= 1'b0;
      r_n_neg    <= 1'b0;
      r_dz       <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_quo      <= {D_IN{1'b0}};
      r_rmd      <= {D_IN{1'b0}};
      r_ovf      <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_busy <= (w_next == CALC) || (w_next == FIX);
      r_done <= (r_state == DONE);
      if (w_load) begin
        r_q     <= w_n_mag;
        r_d_mag <= w_d_mag;
        r_rem   <= {(D_IN+1){1'b0}};
        r_cnt   <= CW'(NW - 1);
        r_q_neg <= N[NW-1] ^ D[D_IN-1];
        r_n_neg <= N[NW-1];
        r_dz    <= (D == {D_IN{1'b0}});
      end else if (r_state == CALC) begin
        r_q   <= {r_q[NW-2:0], ~w_trial[D_IN+1]};
        r_rem <= w_trial[D_IN+1] ? w_shift[D_IN:0] : w_trial[D_IN:0];
        r_cnt <= r_cnt - CW'(1'b1);
      end else if (r_state == FIX) begin
        r_div_zero <= r_dz;
        if (r_dz) begin
          r_quo <= r_n_neg ? Q_MIN : Q_MAX;
          r_rmd <= {D_IN{1'b0}};
          r_ovf <= 1'b0;
        end else begin
          r_quo <= w_q;
          r_rmd <= w_r;
          r_ovf <= w_ovf;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign Q        = r_quo;
  assign R        = r_rmd;
  assign ovf      = r_ovf;
  assign div_zero = r_div_zero;

endmodule
